// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
//  Module : mmio_pkg
//  Brief  : Shared types and helpers for the MMIO interconnect.
//  Rev    : 1.0  initial release
// ============================================================================
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Width of the slot-index field. A single-slot fabric still keeps one
    // index bit, so an address with that bit set decodes as an error.
    function automatic int sel_w(input int num_slv);
        return (num_slv > 1) ? $clog2(num_slv) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_decode.sv
`default_nettype none
// ============================================================================
//  Module : mmio_decode
//  Brief  : Combinational byte address -> slot index and decode-error flag.
//  Rev    : 1.0  initial release
// ============================================================================
module mmio_decode #(
    parameter int NUM_SLV = 4,
    parameter int SEL_LSB = 8,
    parameter int SELW    = 2
) (
    input  logic [31:0]     addr_i,
    output logic [SELW-1:0] idx_o,
    output logic            dec_err_o
);
    localparam int HI_LSB = SEL_LSB + SELW;

    logic [31:0] w_hi;

    assign w_hi      = addr_i >> HI_LSB;
    assign idx_o     = addr_i[SEL_LSB +: SELW];
    // Error if any address bit above the slot field is set, or the slot
    // index points past the last populated slot.
    assign dec_err_o = (w_hi != 32'd0) ||
                       ({{(32-SELW){1'b0}}, idx_o} >= 32'(NUM_SLV));

endmodule
`default_nettype wire

// File: rtl/mmio_fabric.sv
`default_nettype none
// ============================================================================
//  Module : mmio_fabric
//  Brief  : MMIO interconnect between the core data port and NUM_SLV slave
//           slots with ready handshake and decode-error response.
//           Optional macro MMIO_TIMEOUT_EN adds a wait-state timeout.
//  Rev    : 1.0  initial release
// ============================================================================
module mmio_fabric
    import mmio_pkg::*;
#(
    parameter int DW      = 32,
    parameter int NUM_SLV = 4,
    parameter int SEL_LSB = 8,
    parameter int SLV_AW  = 6,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m_valid_i,
    input  logic                  m_we_i,
    input  logic [31:0]           m_addr_i,
    input  logic [DW-1:0]         m_wd_i,
    output logic                  m_ready_o,
    output logic [DW-1:0]         m_rdata_o,
    output logic                  m_err_o,
    output logic                  m_stall_o,
    output logic [NUM_SLV-1:0]    s_sel_o,
    output logic                  s_we_o,
    output logic [SLV_AW-1:0]     s_addr_o,
    output logic [DW-1:0]         s_wd_o,
    input  logic [NUM_SLV*DW-1:0] s_rdata_i,
    input  logic [NUM_SLV-1:0]    s_ready_i
);
    localparam int SELW = sel_w(NUM_SLV);

    state_t              state_q, state_d;
    logic [SLV_AW-1:0]   addr_q,  addr_d;
    logic                we_q,    we_d;
    logic [DW-1:0]       wd_q,    wd_d;
    logic [SELW-1:0]     idx_q,   idx_d;
    logic                err_q,   err_d;
    logic [DW-1:0]       rdata_q, rdata_d;
`ifdef MMIO_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0]       cnt_q,   cnt_d;
`endif

    logic [SELW-1:0]     w_idx;
    logic                w_dec_err;
    logic [NUM_SLV-1:0]  w_sel;
    logic [DW-1:0]       w_rdsel;
    logic                w_rdy;

    mmio_decode #(
        .NUM_SLV (NUM_SLV),
        .SEL_LSB (SEL_LSB),
        .SELW    (SELW)
    ) u_decode (
        .addr_i    (m_addr_i),
        .idx_o     (w_idx),
        .dec_err_o (w_dec_err)
    );

    // One-hot select of the latched slot while waiting, plus AND-OR read mux
    // and ready qualified by the select so unselected slots are ignored.
    always_comb begin
        w_sel   = '0;
        w_rdsel = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            w_sel[i] = (state_q == WAIT) && (idx_q == SELW'(i));
            if (w_sel[i]) begin
                w_rdsel = w_rdsel | s_rdata_i[i*DW +: DW];
            end
        end
        w_rdy = |(w_sel & s_ready_i);
    end

    // Next-state and latch update for the request / wait / response FSM.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wd_d    = wd_q;
        idx_d   = idx_q;
        err_d   = err_q;
        rdata_d = rdata_q;
`ifdef MMIO_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (m_valid_i) begin
                    addr_d  = m_addr_i[SLV_AW+1:2];
                    we_d    = m_we_i;
                    wd_d    = m_wd_i;
                    idx_d   = w_idx;
                    rdata_d = '0;
                    err_d   = w_dec_err;
                    state_d = w_dec_err ? RESP : WAIT;
`ifdef MMIO_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            WAIT: begin
                if (w_rdy) begin
                    rdata_d = we_q ? '0 : w_rdsel;
                    err_d   = 1'b0;
                    state_d = RESP;
                end
`ifdef MMIO_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and transaction latches; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wd_q    <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
`ifdef MMIO_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wd_q    <= wd_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
`ifdef MMIO_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign s_sel_o   = w_sel;
    assign s_we_o    = (state_q == WAIT) && we_q;
    assign s_addr_o  = addr_q;
    assign s_wd_o    = wd_q;
    assign m_ready_o = (state_q == RESP);
    assign m_rdata_o = m_ready_o ? rdata_q : '0;
    assign m_err_o   = m_ready_o && err_q;
    assign m_stall_o = m_valid_i && !m_ready_o;

endmodule
`default_nettype wire

// File: tb/tb_mmio_fabric.sv
`default_nettype none
// ============================================================================
//  Module : tb_mmio_fabric
//  Brief  : Directed self-checking bench for mmio_fabric (4-slot main
//           instance, 3-slot instance for out-of-range slot decode).
//           Honours MMIO_TIMEOUT_EN when defined.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_mmio_fabric;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         m_valid, m_we;
    logic [31:0]  m_addr, m_wd;

    logic         m_ready, m_err, m_stall, s_we;
    logic [31:0]  m_rdata, s_wd;
    logic [3:0]   s_sel, s_ready, extra_rdy;
    logic [5:0]   s_addr;
    logic [127:0] s_rdata;

    logic         m_ready3, m_err3, m_stall3, s_we3;
    logic [31:0]  m_rdata3, s_wd3;
    logic [2:0]   s_sel3;
    logic [5:0]   s_addr3;
    logic [95:0]  s_rdata3;

    int n_pass = 0;
    int n_tot  = 0;
    int sel_cnt = 0;
    int wait_n  = 0;
    int commits = 0;
    int c0;

    always #5 clk = ~clk;

    mmio_fabric #(.DW(32), .NUM_SLV(4), .SEL_LSB(8), .SLV_AW(6), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .m_valid_i(m_valid), .m_we_i(m_we),
        .m_addr_i(m_addr), .m_wd_i(m_wd), .m_ready_o(m_ready), .m_rdata_o(m_rdata),
        .m_err_o(m_err), .m_stall_o(m_stall), .s_sel_o(s_sel), .s_we_o(s_we),
        .s_addr_o(s_addr), .s_wd_o(s_wd), .s_rdata_i(s_rdata), .s_ready_i(s_ready)
    );

    mmio_fabric #(.DW(32), .NUM_SLV(3), .SEL_LSB(8), .SLV_AW(6), .TIMEOUT(16)) dut3 (
        .clk(clk), .rst_n(rst_n), .m_valid_i(m_valid), .m_we_i(m_we),
        .m_addr_i(m_addr), .m_wd_i(m_wd), .m_ready_o(m_ready3), .m_rdata_o(m_rdata3),
        .m_err_o(m_err3), .m_stall_o(m_stall3), .s_sel_o(s_sel3), .s_we_o(s_we3),
        .s_addr_o(s_addr3), .s_wd_o(s_wd3), .s_rdata_i(s_rdata3), .s_ready_i(s_sel3)
    );

    assign s_rdata3 = '0;

    // Slave model: selected slot answers after wait_n select cycles;
    // extra_rdy injects ready on arbitrary slots regardless of select.
    assign s_ready = extra_rdy | ((sel_cnt >= wait_n) ? s_sel : 4'b0000);

    // Count select cycles and committed writes.
    always @(posedge clk) begin
        if (|s_sel) sel_cnt <= sel_cnt + 1;
        else        sel_cnt <= 0;
        if ((|(s_sel & s_ready)) && s_we) commits <= commits + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; m_valid = 1'b0; m_we = 1'b0; m_addr = '0; m_wd = '0;
        extra_rdy = 4'b0000;
        s_rdata = '0;
        s_rdata[0*32 +: 32] = 32'h1111_0000;
        s_rdata[1*32 +: 32] = 32'hDEAD_BEEF;
        s_rdata[2*32 +: 32] = 32'h1234_5678;
        s_rdata[3*32 +: 32] = 32'h3333_3333;

        // Reset state
        #2;
        chk("rst_ready", {31'd0, m_ready}, 32'd0);
        chk("rst_sel",   {28'd0, s_sel},   32'd0);
        chk("rst_err",   {31'd0, m_err},   32'd0);
        chk("rst_rdata", m_rdata,          32'd0);
        chk("rst_we",    {31'd0, s_we},    32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // T1: zero-wait read of slot 1
        wait_n = 0;
        m_valid = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0104;
        tick();
        chk("t1_sel",   {28'd0, s_sel},   32'h2);
        chk("t1_saddr", {26'd0, s_addr},  32'h1);
        chk("t1_swe",   {31'd0, s_we},    32'd0);
        chk("t1_nordy", {31'd0, m_ready}, 32'd0);
        chk("t1_stall", {31'd0, m_stall}, 32'd1);
        tick();
        chk("t1_ready", {31'd0, m_ready}, 32'd1);
        chk("t1_rdata", m_rdata,          32'hDEAD_BEEF);
        chk("t1_err",   {31'd0, m_err},   32'd0);
        chk("t1_selof", {28'd0, s_sel},   32'd0);
        chk("t1_nostl", {31'd0, m_stall}, 32'd0);
        m_valid = 1'b0;
        tick();
        chk("t1_once",  {31'd0, m_ready}, 32'd0);

        // T2: write to slot 2 with three wait cycles
        wait_n = 3; c0 = commits;
        m_valid = 1'b1; m_we = 1'b1; m_addr = 32'h0000_0208; m_wd = 32'h5;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 2) begin
                m_addr = 32'h0000_0000; m_wd = 32'hFFFF_FFFF;
            end
            chk("t2_sel",   {28'd0, s_sel},   32'h4);
            chk("t2_swe",   {31'd0, s_we},    32'd1);
            chk("t2_swd",   s_wd,             32'h5);
            chk("t2_saddr", {26'd0, s_addr},  32'h2);
            chk("t2_nordy", {31'd0, m_ready}, 32'd0);
        end
        tick();
        chk("t2_ready",  {31'd0, m_ready}, 32'd1);
        chk("t2_rdata",  m_rdata,          32'd0);
        chk("t2_err",    {31'd0, m_err},   32'd0);
        chk("t2_commit", 32'(commits - c0), 32'd1);
        m_valid = 1'b0; m_we = 1'b0; m_wd = '0;
        tick();

        // T3: decode errors; valid dropped during WAIT on the 4-slot fabric
        wait_n = 0;
        m_valid = 1'b1; m_addr = 32'h0000_0300;
        tick();
        chk("t3_rdy3",   {31'd0, m_ready3}, 32'd1);
        chk("t3_err3",   {31'd0, m_err3},   32'd1);
        chk("t3_sel3",   {29'd0, s_sel3},   32'd0);
        chk("t3_rdata3", m_rdata3,          32'd0);
        chk("t3_sel4",   {28'd0, s_sel},    32'h8);
        m_valid = 1'b0;
        tick();
        chk("t3_drop_rdy",  {31'd0, m_ready}, 32'd1);
        chk("t3_drop_data", m_rdata,          32'h3333_3333);
        tick();
        m_valid = 1'b1; m_addr = 32'h0001_0000;
        tick();
        chk("t3_hi_rdy", {31'd0, m_ready}, 32'd1);
        chk("t3_hi_err", {31'd0, m_err},   32'd1);
        chk("t3_hi_sel", {28'd0, s_sel},   32'd0);
        m_valid = 1'b0;
        tick();

        // T4: slot 0 never ready
        wait_n = 1000;
        m_valid = 1'b1; m_addr = 32'h0000_0000;
`ifdef MMIO_TIMEOUT_EN
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 1 || k == 16) begin
                chk("t4_sel",   {28'd0, s_sel},   32'h1);
                chk("t4_nordy", {31'd0, m_ready}, 32'd0);
            end
        end
        tick();
        chk("t4_to_sel",   {28'd0, s_sel},   32'd0);
        chk("t4_to_rdy",   {31'd0, m_ready}, 32'd1);
        chk("t4_to_err",   {31'd0, m_err},   32'd1);
        chk("t4_to_rdata", m_rdata,          32'd0);
`else
        for (int k = 1; k <= 100; k++) tick();
        chk("t4_sel",   {28'd0, s_sel},   32'h1);
        chk("t4_stall", {31'd0, m_stall}, 32'd1);
        chk("t4_nordy", {31'd0, m_ready}, 32'd0);
        wait_n = 0;
        tick();
        chk("t4_rdy",   {31'd0, m_ready}, 32'd1);
        chk("t4_err",   {31'd0, m_err},   32'd0);
        chk("t4_rdata", m_rdata,          32'h1111_0000);
`endif
        m_valid = 1'b0;
        tick();

        // T5: reset asserted during WAIT
        wait_n = 1000;
        m_valid = 1'b1; m_we = 1'b1; m_addr = 32'h0000_0104; m_wd = 32'hAA;
        tick();
        chk("t5_sel_pre", {28'd0, s_sel}, 32'h2);
        rst_n = 1'b0; m_valid = 1'b0; m_we = 1'b0;
        #1;
        chk("t5_sel",   {28'd0, s_sel},   32'd0);
        chk("t5_swe",   {31'd0, s_we},    32'd0);
        chk("t5_swd",   s_wd,             32'd0);
        chk("t5_saddr", {26'd0, s_addr},  32'd0);
        chk("t5_rdy",   {31'd0, m_ready}, 32'd0);
        chk("t5_stall", {31'd0, m_stall}, 32'd0);
        tick(); tick();
        chk("t5_rdy2",  {31'd0, m_ready}, 32'd0);
        rst_n = 1'b1;
        wait_n = 0;
        tick();
        m_valid = 1'b1; m_addr = 32'h0000_0104;
        tick();
        tick();
        chk("t5_post_rdy",   {31'd0, m_ready}, 32'd1);
        chk("t5_post_rdata", m_rdata,          32'hDEAD_BEEF);
        m_valid = 1'b0;
        tick();

        // T6: back-to-back reads slot 0 then slot 3 with stray readies
        wait_n = 2; extra_rdy = 4'b1110;
        m_valid = 1'b1; m_addr = 32'h0000_0000;
        tick();
        chk("t6_sel0",  {28'd0, s_sel},   32'h1);
        tick();
        chk("t6_ign",   {31'd0, m_ready}, 32'd0);
        tick();
        tick();
        chk("t6_rdy0",   {31'd0, m_ready}, 32'd1);
        chk("t6_rdata0", m_rdata,          32'h1111_0000);
        m_addr = 32'h0000_0300; wait_n = 0; extra_rdy = 4'b0111;
        tick();
        chk("t6_gap_rdy", {31'd0, m_ready}, 32'd0);
        chk("t6_gap_sel", {28'd0, s_sel},   32'd0);
        tick();
        chk("t6_sel3", {28'd0, s_sel}, 32'h8);
        tick();
        chk("t6_rdy3",   {31'd0, m_ready}, 32'd1);
        chk("t6_rdata3", m_rdata,          32'h3333_3333);
        m_valid = 1'b0; extra_rdy = 4'b0000;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
`default_nettype wire
